// File: rtl/sprite_fetch.sv
// sprite_fetch: per-frame reader of the sprite register bank.
// On frame_start it checks the work-done flag, walks attribute registers
// 0..LAST_ADDR into a shadow set, then commits the whole set to the output
// bank on a single edge so the renderer never sees a half-updated frame.
// The output mapping below assumes the standard layout, i.e. LAST_ADDR >= 16.
module sprite_fetch #(
    parameter int FLAG_ADDR = 17,
    parameter int LAST_ADDR = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic [5:0]  reg_addr,
    input  logic [7:0]  reg_data,
    output logic        busy,
    output logic [7:0]  pac_x,
    output logic [7:0]  pac_y,
    output logic [7:0]  map_x,
    output logic [7:0]  map_y,
    output logic [31:0] ghost_x,
    output logic [31:0] ghost_y,
    output logic [9:0]  rot,
    output logic        commit,
    output logic        skipped,
    output logic        overrun
);

    localparam logic [5:0] FLAG_A   = 6'(FLAG_ADDR);
    localparam logic [4:0] LAST_IDX = 5'(LAST_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLAG,
        ST_FETCH,
        ST_COMMIT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  idx;
    logic [7:0]  shadow [0:LAST_ADDR];
    logic        commit_d;
    logic        skip_d;
    logic        overrun_d;

    // State register; reset drops any fetch in flight back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, bank read address, busy and the pulse requests.
    always_comb begin
        next_state = state;
        reg_addr   = 6'd0;
        busy       = 1'b1;
        commit_d   = 1'b0;
        skip_d     = 1'b0;
        overrun_d  = frame_start && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    next_state = ST_FLAG;
                end
            end
            ST_FLAG: begin
                reg_addr = FLAG_A;
                if (reg_data == 8'd0) begin
                    next_state = ST_IDLE;
                    skip_d     = 1'b1;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                reg_addr = {1'b0, idx};
                if (idx == LAST_IDX) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                next_state = ST_IDLE;
                commit_d   = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Index counter: cleared on entering the walk, saturates at LAST_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 5'd0;
        end else if (state == ST_FLAG) begin
            idx <= 5'd0;
        end else if ((state == ST_FETCH) && (idx != LAST_IDX)) begin
            idx <= idx + 5'd1;
        end
    end

    // Shadow set captures one bank byte per fetch cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAST_ADDR; i++) begin
                shadow[i] <= 8'd0;
            end
        end else if (state == ST_FETCH) begin
            shadow[idx] <= reg_data;
        end
    end

    // Output bank: loaded from the shadow set only on the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pac_x   <= 8'd0;
            pac_y   <= 8'd0;
            map_x   <= 8'd0;
            map_y   <= 8'd0;
            ghost_x <= 32'd0;
            ghost_y <= 32'd0;
            rot     <= 10'd0;
        end else if (state == ST_COMMIT) begin
            pac_x   <= shadow[0];
            pac_y   <= shadow[1];
            map_x   <= shadow[3];
            map_y   <= shadow[4];
            ghost_x <= {shadow[14], shadow[11], shadow[8], shadow[5]};
            ghost_y <= {shadow[15], shadow[12], shadow[9], shadow[6]};
            rot     <= {shadow[16][1:0], shadow[13][1:0], shadow[10][1:0],
                        shadow[7][1:0], shadow[2][1:0]};
        end
    end

    // Status pulses appear the cycle after the event that caused them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit  <= 1'b0;
            skipped <= 1'b0;
            overrun <= 1'b0;
        end else begin
            commit  <= commit_d;
            skipped <= skip_d;
            overrun <= overrun_d;
        end
    end

endmodule
